// File: rtl/spi_slave_fifo_v2x_if.sv
// Signal bundle for spi_slave_fifo_v2x: FIFO handshakes, status flags, SPI pins and mode straps.
// The slave modport is the FPGA-side view; the master modport is the command engine / ESP32 side.
interface spi_slave_fifo_v2x_if #(
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 8
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic [DATA_WIDTH-1:0] i_tx_data;
  logic                  i_tx_valid;
  logic                  o_tx_ready;
  logic [DATA_WIDTH-1:0] o_rx_data;
  logic                  o_rx_valid;
  logic                  i_rx_ready;
  logic [LW-1:0]         o_tx_level;
  logic [LW-1:0]         o_rx_level;
  logic                  o_tx_underrun;
  logic                  o_rx_overrun;
  logic                  o_frame_err;
  logic                  i_err_clr;
  logic                  o_cs_active;
  logic                  i_spi_sclk;
  logic                  i_spi_cs_n;
  logic                  i_spi_mosi;
  logic                  o_spi_miso;
  logic                  o_spi_miso_oe;
  logic                  i_cpol;
  logic                  i_cpha;
  logic                  i_lsb_first;

  modport slave (
    input  i_tx_data, i_tx_valid, i_rx_ready, i_err_clr,
    input  i_spi_sclk, i_spi_cs_n, i_spi_mosi, i_cpol, i_cpha, i_lsb_first,
    output o_tx_ready, o_rx_data, o_rx_valid, o_tx_level, o_rx_level,
    output o_tx_underrun, o_rx_overrun, o_frame_err, o_cs_active,
    output o_spi_miso, o_spi_miso_oe
  );

  modport master (
    output i_tx_data, i_tx_valid, i_rx_ready, i_err_clr,
    output i_spi_sclk, i_spi_cs_n, i_spi_mosi, i_cpol, i_cpha, i_lsb_first,
    input  o_tx_ready, o_rx_data, o_rx_valid, o_tx_level, o_rx_level,
    input  o_tx_underrun, o_rx_overrun, o_frame_err, o_cs_active,
    input  o_spi_miso, o_spi_miso_oe
  );
endinterface

// File: rtl/spi_slave_fifo_v2x.sv
// Oversampled SPI slave (all CPOL/CPHA modes, MSB/LSB first) with TX/RX FIFOs for the V2X HSM link.
//
// state | meaning
// IDLE  | CS_n high, MISO low, waiting for synchronised CS fall
// LOAD  | one cycle: pop TX head (or TX_FILL) into the shift register
// SHIFT | sample/drive bits on SCLK edges, reload at each word boundary
module spi_slave_fifo_v2x #(
  parameter int                    DATA_WIDTH  = 16,
  parameter int                    FIFO_DEPTH  = 8,
  parameter int                    SYNC_STAGES = 2,
  parameter logic [DATA_WIDTH-1:0] TX_FILL     = '0
) (
  input logic                 i_sys_clk,
  input logic                 i_sys_rst,
  spi_slave_fifo_v2x_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(DATA_WIDTH + 1);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

  function automatic logic first_bit(input logic [DATA_WIDTH-1:0] w, input logic lsb);
    return lsb ? w[0] : w[DATA_WIDTH-1];
  endfunction

  function automatic logic [DATA_WIDTH-1:0] shift_out(input logic [DATA_WIDTH-1:0] w, input logic lsb);
    return lsb ? (w >> 1) : (w << 1);
  endfunction

  // CS chain resets to "low" so a reset taken mid-frame never sees a false CS fall
  logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
  logic                   sclk_d, cs_d;

  always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
    if (i_sys_rst) begin
      sclk_sync <= '0;
      cs_sync   <= '0;
      mosi_sync <= '0;
      sclk_d    <= 1'b0;
      cs_d      <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], bus.i_spi_sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], bus.i_spi_cs_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.i_spi_mosi};
      sclk_d    <= sclk_sync[SYNC_STAGES-1];
      cs_d      <= cs_sync[SYNC_STAGES-1];
    end
  end

  logic sclk_q, cs_q, mosi_q;
  assign sclk_q = sclk_sync[SYNC_STAGES-1];
  assign cs_q   = cs_sync[SYNC_STAGES-1];
  assign mosi_q = mosi_sync[SYNC_STAGES-1];

  state_t                state;
  logic [CW-1:0]         cnt;
  logic [DATA_WIDTH-1:0] tx_sr, rx_sr;
  logic                  miso, cs_active, word_done, frame_err;
  logic                  cpol_r, cpha_r, lsb_r;

  logic cs_fall, cs_rise, lead_edge, trail_edge, sample_edge, drive_edge;
  assign cs_fall     = cs_d & ~cs_q;
  assign cs_rise     = ~cs_d & cs_q;
  assign lead_edge   = (sclk_q ^ sclk_d) & (sclk_d == cpol_r);
  assign trail_edge  = (sclk_q ^ sclk_d) & (sclk_q == cpol_r);
  assign sample_edge = cpha_r ? trail_edge : lead_edge;
  assign drive_edge  = cpha_r ? lead_edge : trail_edge;

  logic [DATA_WIDTH-1:0] tx_mem [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] rx_mem [FIFO_DEPTH];
  logic [AW-1:0]         tx_wr, tx_rd, rx_wr, rx_rd;
  logic [LW-1:0]         tx_lvl, rx_lvl;
  logic                  tx_full, tx_empty, rx_full, rx_empty;
  logic                  underrun, overrun;

  assign tx_full  = (tx_lvl == LW'(FIFO_DEPTH));
  assign tx_empty = (tx_lvl == '0);
  assign rx_full  = (rx_lvl == LW'(FIFO_DEPTH));
  assign rx_empty = (rx_lvl == '0);

  // CPHA=1 reloads together with the RX push; CPHA=0 waits for the drive edge after the last sample
  logic                  boundary, load_now;
  logic [DATA_WIDTH-1:0] load_word;
  assign boundary  = (state == SHIFT) && !cs_rise &&
                     (cpha_r ? word_done : (drive_edge && cnt == CW'(DATA_WIDTH)));
  assign load_now  = ((state == LOAD) && !cs_rise) || boundary;
  assign load_word = tx_empty ? TX_FILL : tx_mem[tx_rd];

  logic tx_push, tx_pop, rx_push, rx_pop, rx_wr_en;
  assign tx_push  = bus.i_tx_valid & ~tx_full;
  assign tx_pop   = load_now & ~tx_empty;
  assign rx_push  = word_done;
  assign rx_pop   = ~rx_empty & bus.i_rx_ready;
  assign rx_wr_en = rx_push & (~rx_full | rx_pop);

  always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
    if (i_sys_rst) begin
      state     <= IDLE;
      cnt       <= '0;
      tx_sr     <= '0;
      rx_sr     <= '0;
      miso      <= 1'b0;
      cs_active <= 1'b0;
      word_done <= 1'b0;
      frame_err <= 1'b0;
      cpol_r    <= 1'b0;
      cpha_r    <= 1'b0;
      lsb_r     <= 1'b0;
    end else begin
      word_done <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          miso      <= 1'b0;
          cs_active <= 1'b0;
          cnt       <= '0;
          if (cs_fall) begin
            cpol_r    <= bus.i_cpol;
            cpha_r    <= bus.i_cpha;
            lsb_r     <= bus.i_lsb_first;
            cs_active <= 1'b1;
            state     <= LOAD;
          end
        end
        LOAD, SHIFT: begin
          if (cs_rise) begin
            frame_err <= (cnt != '0) && (cnt != CW'(DATA_WIDTH));
            miso      <= 1'b0;
            cs_active <= 1'b0;
            cnt       <= '0;
            state     <= IDLE;
          end else if (load_now) begin
            tx_sr <= cpha_r ? load_word : shift_out(load_word, lsb_r);
            if (!cpha_r) miso <= first_bit(load_word, lsb_r);
            cnt   <= '0;
            state <= SHIFT;
          end else begin
            if (sample_edge && cnt != CW'(DATA_WIDTH)) begin
              rx_sr     <= lsb_r ? {mosi_q, rx_sr[DATA_WIDTH-1:1]}
                                 : {rx_sr[DATA_WIDTH-2:0], mosi_q};
              cnt       <= cnt + CW'(1);
              word_done <= (cnt == CW'(DATA_WIDTH - 1));
            end
            if (drive_edge) begin
              miso  <= first_bit(tx_sr, lsb_r);
              tx_sr <= shift_out(tx_sr, lsb_r);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // storage carries no reset; emptiness is defined by the pointers and levels alone
  always_ff @(posedge i_sys_clk) begin
    if (tx_push)  tx_mem[tx_wr] <= bus.i_tx_data;
    if (rx_wr_en) rx_mem[rx_wr] <= rx_sr;
  end

  always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
    if (i_sys_rst) begin
      tx_wr    <= '0;
      tx_rd    <= '0;
      rx_wr    <= '0;
      rx_rd    <= '0;
      tx_lvl   <= '0;
      rx_lvl   <= '0;
      underrun <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      if (tx_push)  tx_wr <= tx_wr + AW'(1);
      if (tx_pop)   tx_rd <= tx_rd + AW'(1);
      if (rx_wr_en) rx_wr <= rx_wr + AW'(1);
      if (rx_pop)   rx_rd <= rx_rd + AW'(1);
      case ({tx_push, tx_pop})
        2'b10:   tx_lvl <= tx_lvl + LW'(1);
        2'b01:   tx_lvl <= tx_lvl - LW'(1);
        default: ;
      endcase
      case ({rx_wr_en, rx_pop})
        2'b10:   rx_lvl <= rx_lvl + LW'(1);
        2'b01:   rx_lvl <= rx_lvl - LW'(1);
        default: ;
      endcase
      underrun <= (underrun & ~bus.i_err_clr) | (load_now & tx_empty);
      overrun  <= (overrun & ~bus.i_err_clr) | (rx_push & rx_full & ~rx_pop);
    end
  end

  assign bus.o_tx_ready    = ~tx_full;
  assign bus.o_tx_level    = tx_lvl;
  assign bus.o_rx_level    = rx_lvl;
  assign bus.o_rx_valid    = ~rx_empty;
  assign bus.o_rx_data     = rx_empty ? '0 : rx_mem[rx_rd];
  assign bus.o_tx_underrun = underrun;
  assign bus.o_rx_overrun  = overrun;
  assign bus.o_frame_err   = frame_err;
  assign bus.o_cs_active   = cs_active;
  assign bus.o_spi_miso    = miso;
  assign bus.o_spi_miso_oe = cs_active;
endmodule

// File: tb/tb_spi_slave_fifo_v2x.sv
// Directed bench for spi_slave_fifo_v2x: a behavioural SPI master exchanges words with the slave
// and every received/transmitted word is compared with hand-computed values.
module tb_spi_slave_fifo_v2x;
  localparam int              DW   = 16;
  localparam int              HALF = 80;
  localparam logic [DW-1:0]   FILL = 16'hF00D;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_fail = 0;
  int   fe_count = 0;
  logic m_cpol = 1'b0, m_cpha = 1'b0, m_lsb = 1'b0;

  spi_slave_fifo_v2x_if #(.DATA_WIDTH(DW), .FIFO_DEPTH(8)) bus ();

  spi_slave_fifo_v2x #(
    .DATA_WIDTH(DW), .FIFO_DEPTH(8), .SYNC_STAGES(2), .TX_FILL(FILL)
  ) dut (
    .i_sys_clk(clk),
    .i_sys_rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (bus.o_frame_err) fe_count++;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

  task automatic tx_write(input logic [DW-1:0] w);
    @(negedge clk); bus.i_tx_data = w; bus.i_tx_valid = 1'b1;
    @(negedge clk); bus.i_tx_valid = 1'b0;
  endtask

  task automatic rx_pop();
    @(negedge clk); bus.i_rx_ready = 1'b1;
    @(negedge clk); bus.i_rx_ready = 1'b0;
  endtask

  task automatic err_clear();
    @(negedge clk); bus.i_err_clr = 1'b1;
    @(negedge clk); bus.i_err_clr = 1'b0;
  endtask

  task automatic cs_assert();
    bus.i_cpol = m_cpol; bus.i_cpha = m_cpha; bus.i_lsb_first = m_lsb;
    bus.i_spi_sclk = m_cpol;
    #100; bus.i_spi_cs_n = 1'b0;
    #100;
  endtask

  task automatic cs_release();
    #HALF; bus.i_spi_cs_n = 1'b1;
    #200;
  endtask

  task automatic xfer(input logic [DW-1:0] w, input int nbits, output logic [DW-1:0] r);
    int pos;
    r = '0;
    for (int i = 0; i < nbits; i++) begin
      pos = m_lsb ? i : DW - 1 - i;
      if (!m_cpha) begin
        bus.i_spi_mosi = w[pos]; #HALF;
        r[pos] = bus.o_spi_miso; bus.i_spi_sclk = ~m_cpol; #HALF;
        bus.i_spi_sclk = m_cpol;
      end else begin
        #HALF; bus.i_spi_sclk = ~m_cpol; bus.i_spi_mosi = w[pos]; #HALF;
        r[pos] = bus.o_spi_miso; bus.i_spi_sclk = m_cpol;
      end
    end
  endtask

  task automatic test_reset();
    logic [7:0] flags;
    flags = {bus.o_tx_ready, bus.o_rx_valid, bus.o_tx_underrun, bus.o_rx_overrun,
             bus.o_frame_err, bus.o_cs_active, bus.o_spi_miso, bus.o_spi_miso_oe};
    n_cmp++;
    if (flags !== 8'b1000_0000) begin
      n_fail++; $display("FAIL reset_flags: got %b expected %b", flags, 8'b1000_0000);
    end
    n_cmp++;
    if ({bus.o_tx_level, bus.o_rx_level} !== 8'h00) begin
      n_fail++; $display("FAIL reset_levels: got tx=%0d rx=%0d expected 0/0", bus.o_tx_level, bus.o_rx_level);
    end
    n_cmp++;
    if (bus.o_rx_data !== 16'h0000) begin
      n_fail++; $display("FAIL reset_rx_data: got %h expected 0000", bus.o_rx_data);
    end
  endtask

  task automatic test_mode0();
    logic [DW-1:0] r;
    m_cpol = 0; m_cpha = 0; m_lsb = 0;
    tx_write(16'hA55A);
    n_cmp++;
    if (bus.o_tx_level !== 4'd1) begin
      n_fail++; $display("FAIL mode0_tx_level_before: got %0d expected 1", bus.o_tx_level);
    end
    cs_assert();
    n_cmp++;
    if ({bus.o_cs_active, bus.o_spi_miso_oe} !== 2'b11) begin
      n_fail++; $display("FAIL mode0_cs_active: got %b expected 11", {bus.o_cs_active, bus.o_spi_miso_oe});
    end
    xfer(16'h1234, DW, r);
    cs_release();
    n_cmp++;
    if (r !== 16'hA55A) begin
      n_fail++; $display("FAIL mode0_miso: got %h expected a55a", r);
    end
    n_cmp++;
    if ({bus.o_rx_valid, bus.o_rx_data} !== {1'b1, 16'h1234}) begin
      n_fail++; $display("FAIL mode0_rx: got v=%b %h expected v=1 1234", bus.o_rx_valid, bus.o_rx_data);
    end
    n_cmp++;
    if ({bus.o_tx_level, bus.o_cs_active, bus.o_spi_miso} !== 6'b0) begin
      n_fail++; $display("FAIL mode0_after: got lvl=%0d cs=%b miso=%b expected 0/0/0",
                         bus.o_tx_level, bus.o_cs_active, bus.o_spi_miso);
    end
    rx_pop();
    err_clear();
  endtask

  task automatic test_modes();
    logic [2:0]    modes [5] = '{3'b010, 3'b100, 3'b110, 3'b001, 3'b111};
    logic [DW-1:0] r;
    for (int k = 0; k < 5; k++) begin
      {m_cpol, m_cpha, m_lsb} = modes[k];
      tx_write(16'h00FF);
      cs_assert();
      xfer(16'h8001, DW, r);
      cs_release();
      n_cmp++;
      if (r !== 16'h00FF) begin
        n_fail++; $display("FAIL modes_miso[%b]: got %h expected 00ff", modes[k], r);
      end
      n_cmp++;
      if ({bus.o_rx_level, bus.o_rx_data} !== {4'd1, 16'h8001}) begin
        n_fail++; $display("FAIL modes_rx[%b]: got lvl=%0d %h expected 1 8001", modes[k], bus.o_rx_level, bus.o_rx_data);
      end
      rx_pop();
    end
    err_clear();
  endtask

  task automatic test_multiword();
    logic [DW-1:0] mosi_w [3] = '{16'h1111, 16'h2222, 16'h3333};
    logic [DW-1:0] miso_e [3] = '{16'hAAAA, 16'h5555, FILL};
    logic [DW-1:0] r;
    m_cpol = 0; m_cpha = 0; m_lsb = 0;
    n_cmp++;
    if (bus.o_tx_underrun !== 1'b0) begin
      n_fail++; $display("FAIL multi_underrun_clr: got %b expected 0", bus.o_tx_underrun);
    end
    tx_write(16'hAAAA);
    tx_write(16'h5555);
    cs_assert();
    for (int k = 0; k < 3; k++) begin
      xfer(mosi_w[k], DW, r);
      n_cmp++;
      if (r !== miso_e[k]) begin
        n_fail++; $display("FAIL multi_miso[%0d]: got %h expected %h", k, r, miso_e[k]);
      end
    end
    cs_release();
    n_cmp++;
    if ({bus.o_rx_level, bus.o_tx_underrun} !== {4'd3, 1'b1}) begin
      n_fail++; $display("FAIL multi_status: got lvl=%0d urun=%b expected 3 1", bus.o_rx_level, bus.o_tx_underrun);
    end
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (bus.o_rx_data !== mosi_w[k]) begin
        n_fail++; $display("FAIL multi_rx[%0d]: got %h expected %h", k, bus.o_rx_data, mosi_w[k]);
      end
      rx_pop();
    end
    err_clear();
  endtask

  task automatic test_overrun();
    logic [DW-1:0] r;
    m_cpol = 0; m_cpha = 0; m_lsb = 0;
    for (int k = 0; k < 9; k++) tx_write(16'hC000 + 16'(k));
    n_cmp++;
    if ({bus.o_tx_ready, bus.o_tx_level} !== {1'b0, 4'd8}) begin
      n_fail++; $display("FAIL tx_full: got rdy=%b lvl=%0d expected 0 8", bus.o_tx_ready, bus.o_tx_level);
    end
    cs_assert();
    for (int k = 0; k < 9; k++) begin
      xfer(16'h0100 + 16'(k), DW, r);
      n_cmp++;
      if (r !== ((k < 8) ? 16'hC000 + 16'(k) : FILL)) begin
        n_fail++; $display("FAIL ovr_miso[%0d]: got %h expected %h", k, r, (k < 8) ? 16'hC000 + 16'(k) : FILL);
      end
    end
    cs_release();
    n_cmp++;
    if ({bus.o_rx_level, bus.o_rx_overrun, bus.o_rx_data} !== {4'd8, 1'b1, 16'h0100}) begin
      n_fail++; $display("FAIL ovr_status: got lvl=%0d ovr=%b head=%h expected 8 1 0100",
                         bus.o_rx_level, bus.o_rx_overrun, bus.o_rx_data);
    end
    err_clear();
    n_cmp++;
    if (bus.o_rx_overrun !== 1'b0) begin
      n_fail++; $display("FAIL ovr_clear: got %b expected 0", bus.o_rx_overrun);
    end
    for (int k = 0; k < 8; k++) begin
      n_cmp++;
      if (bus.o_rx_data !== 16'h0100 + 16'(k)) begin
        n_fail++; $display("FAIL ovr_drain[%0d]: got %h expected %h", k, bus.o_rx_data, 16'h0100 + 16'(k));
      end
      rx_pop();
    end
    n_cmp++;
    if (bus.o_rx_valid !== 1'b0) begin
      n_fail++; $display("FAIL ovr_dropped: got valid=%b expected 0", bus.o_rx_valid);
    end
    err_clear();
  endtask

  task automatic test_frame_err();
    logic [DW-1:0] r;
    int            fe0;
    m_cpol = 0; m_cpha = 0; m_lsb = 0;
    fe0 = fe_count;
    cs_assert();
    xfer(16'hFFFF, 9, r);
    cs_release();
    n_cmp++;
    if (fe_count - fe0 !== 1) begin
      n_fail++; $display("FAIL frame_err_pulse: got %0d cycles expected 1", fe_count - fe0);
    end
    n_cmp++;
    if (bus.o_rx_level !== 4'd0) begin
      n_fail++; $display("FAIL frame_err_level: got %0d expected 0", bus.o_rx_level);
    end
    cs_assert();
    xfer(16'h4321, DW, r);
    cs_release();
    n_cmp++;
    if ({bus.o_rx_level, bus.o_rx_data} !== {4'd1, 16'h4321} || fe_count - fe0 !== 1) begin
      n_fail++; $display("FAIL frame_err_next: got lvl=%0d %h errs=%0d expected 1 4321 1",
                         bus.o_rx_level, bus.o_rx_data, fe_count - fe0);
    end
    rx_pop();
    err_clear();
  endtask

  task automatic test_reset_midframe();
    logic [DW-1:0] r;
    logic [7:0]    flags;
    m_cpol = 0; m_cpha = 0; m_lsb = 0;
    tx_write(16'h7777);
    tx_write(16'h6666);
    cs_assert();
    xfer(16'hFFFF, 5, r);
    rst = 1'b1;
    #20;
    flags = {bus.o_tx_ready, bus.o_rx_valid, bus.o_tx_underrun, bus.o_rx_overrun,
             bus.o_frame_err, bus.o_cs_active, bus.o_spi_miso, bus.o_spi_miso_oe};
    n_cmp++;
    if (flags !== 8'b1000_0000 || {bus.o_tx_level, bus.o_rx_level} !== 8'h00) begin
      n_fail++; $display("FAIL rst_mid_state: got flags=%b tx=%0d rx=%0d expected 10000000 0 0",
                         flags, bus.o_tx_level, bus.o_rx_level);
    end
    #20; rst = 1'b0;
    #200;
    n_cmp++;
    if (bus.o_cs_active !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_no_resume: got cs_active=%b expected 0", bus.o_cs_active);
    end
    bus.i_spi_cs_n = 1'b1;
    #200;
    cs_assert();
    xfer(16'hBEEF, DW, r);
    cs_release();
    n_cmp++;
    if ({bus.o_rx_level, bus.o_rx_data} !== {4'd1, 16'hBEEF}) begin
      n_fail++; $display("FAIL rst_mid_beef: got lvl=%0d %h expected 1 beef", bus.o_rx_level, bus.o_rx_data);
    end
    n_cmp++;
    if (r !== FILL) begin
      n_fail++; $display("FAIL rst_mid_miso: got %h expected %h", r, FILL);
    end
    rx_pop();
  endtask

  initial begin
    bus.i_tx_data = '0; bus.i_tx_valid = 1'b0; bus.i_rx_ready = 1'b0; bus.i_err_clr = 1'b0;
    bus.i_spi_sclk = 1'b0; bus.i_spi_cs_n = 1'b1; bus.i_spi_mosi = 1'b0;
    bus.i_cpol = 1'b0; bus.i_cpha = 1'b0; bus.i_lsb_first = 1'b0;
    #40; rst = 1'b0;
    #20;
    test_reset();
    test_mode0();
    test_modes();
    test_multiword();
    test_overrun();
    test_frame_err();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
